// File: rtl/ocimem_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : ocimem_pkg                                                 |
// | Purpose  : Shared types and constants for the OCI RAM access arbiter. |
// |            Holds the FSM state enum, width defaults and the grant     |
// |            encoding.                                                  |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
package ocimem_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;

  // Grant encoding used by the arbiter
  localparam logic GRANT_CPU  = 1'b0;
  localparam logic GRANT_JTAG = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CPU_ACC   = 3'd1,
    ST_CPU_DONE  = 3'd2,
    ST_JTAG_ACC  = 3'd3,
    ST_JTAG_DONE = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ocimem_jtag_ptr.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : ocimem_jtag_ptr                                            |
// | Purpose  : JTAG auto-increment address pointer, one-deep request      |
// |            capture register, pending flag and sticky overrun flag.    |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
module ocimem_jtag_ptr
  import ocimem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_addr_ld,
  input  logic [ADDR_W-1:0] i_addr_in,
  input  logic              i_acc,
  input  logic              i_wr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_clr_pend,
  output logic              o_pending,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_wr,
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_overrun
);

  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_pending;
  logic              r_overrun;

  // A load in the same cycle as an access redirects that access
  logic [ADDR_W-1:0] w_base;
  logic              w_accept;
  logic              w_drop;

  assign w_base   = i_addr_ld ? i_addr_in : r_ptr;
  assign w_accept = i_acc & ~r_pending;
  assign w_drop   = i_acc & r_pending;

  // Pointer, capture register, pending and overrun state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr     <= '0;
      r_addr    <= '0;
      r_wr      <= 1'b0;
      r_wdata   <= '0;
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr  <= w_base;
        r_wr    <= i_wr;
        r_wdata <= i_wdata;
        r_ptr   <= w_base + ADDR_W'(1);
      end else if (i_addr_ld) begin
        // Pending request (if any) keeps its captured address
        r_ptr <= i_addr_in;
      end

      // Accept and clear never coincide: accept needs pending low
      if (w_accept) begin
        r_pending <= 1'b1;
      end else if (i_clr_pend) begin
        r_pending <= 1'b0;
      end

      // A drop in the same cycle as a load keeps the flag set
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (i_addr_ld) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign o_pending = r_pending;
  assign o_addr    = r_addr;
  assign o_wr      = r_wr;
  assign o_wdata   = r_wdata;
  assign o_overrun = r_overrun;

endmodule
`default_nettype wire

// File: rtl/ocimem_access_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : ocimem_access_arbiter                                      |
// | Purpose  : Shares the single-port OCI debug RAM between the JTAG      |
// |            debug module strobes and the CPU Avalon debug slave, one   |
// |            access at a time.                                          |
// | Options  : OCIMEM_RR_ARB_EN - round-robin arbitration on contention;  |
// |            undefined gives fixed JTAG-over-CPU priority.              |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
module ocimem_access_arbiter
  import ocimem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_jtag_addr_ld,
  input  logic [ADDR_W-1:0]   i_jtag_addr_in,
  input  logic                i_jtag_acc,
  input  logic                i_jtag_wr,
  input  logic [DATA_W-1:0]   i_jtag_wdata,
  output logic                o_jtag_done,
  output logic [DATA_W-1:0]   o_jtag_rdata,
  output logic                o_jtag_overrun,
  input  logic [ADDR_W-1:0]   i_cpu_address,
  input  logic                i_cpu_read,
  input  logic                i_cpu_write,
  input  logic [DATA_W-1:0]   i_cpu_writedata,
  input  logic [DATA_W/8-1:0] i_cpu_byteenable,
  output logic                o_cpu_waitrequest,
  output logic [DATA_W-1:0]   o_cpu_readdata,
  output logic [ADDR_W-1:0]   o_ram_addr,
  output logic                o_ram_we,
  output logic [DATA_W/8-1:0] o_ram_be,
  output logic [DATA_W-1:0]   o_ram_wdata,
  input  logic [DATA_W-1:0]   i_ram_rdata
);

  state_t r_state;
  state_t w_next;

  logic              w_cpu_req;
  logic              w_jtag_pend;
  logic [ADDR_W-1:0] w_jtag_addr;
  logic              w_jtag_wr;
  logic [DATA_W-1:0] w_jtag_wdata;
  logic              w_grant;
  logic              w_cpu_rd_done;
  logic              w_jtag_rd_done;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_jtag_rdata;

  assign w_cpu_req = i_cpu_read | i_cpu_write;

  ocimem_jtag_ptr #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_jtag_ptr (
    .clk        (clk),
    .reset      (reset),
    .i_addr_ld  (i_jtag_addr_ld),
    .i_addr_in  (i_jtag_addr_in),
    .i_acc      (i_jtag_acc),
    .i_wr       (i_jtag_wr),
    .i_wdata    (i_jtag_wdata),
    .i_clr_pend (r_state == ST_JTAG_DONE),
    .o_pending  (w_jtag_pend),
    .o_addr     (w_jtag_addr),
    .o_wr       (w_jtag_wr),
    .o_wdata    (w_jtag_wdata),
    .o_overrun  (o_jtag_overrun)
  );

`ifdef OCIMEM_RR_ARB_EN
  // Requester favoured on the next contention (the one not granted last)
  logic r_prio;

  // Contention follows r_prio, a lone requester is always granted
  always_comb begin
    w_grant = w_jtag_pend ? GRANT_JTAG : GRANT_CPU;
    if (w_jtag_pend && w_cpu_req) begin
      w_grant = r_prio;
    end
  end

  // Flip priority to the other requester after every grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prio <= GRANT_CPU;
    end else if ((r_state == ST_IDLE) && (w_jtag_pend || w_cpu_req)) begin
      r_prio <= ~w_grant;
    end
  end
`else
  // JTAG has at most one outstanding request, so CPU wait is bounded
  assign w_grant = w_jtag_pend ? GRANT_JTAG : GRANT_CPU;
`endif

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and RAM-side drive
  always_comb begin
    w_next      = r_state;
    o_ram_addr  = '0;
    o_ram_we    = 1'b0;
    o_ram_be    = '0;
    o_ram_wdata = '0;
    o_jtag_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_jtag_pend || w_cpu_req) begin
          w_next = (w_grant == GRANT_JTAG) ? ST_JTAG_ACC : ST_CPU_ACC;
        end
      end
      ST_CPU_ACC: begin
        o_ram_addr = i_cpu_address;
        o_ram_be   = i_cpu_byteenable;
        // Read and write together is treated as a write
        if (i_cpu_write) begin
          o_ram_we    = 1'b1;
          o_ram_wdata = i_cpu_writedata;
        end
        w_next = ST_CPU_DONE;
      end
      ST_CPU_DONE: begin
        w_next = ST_IDLE;
      end
      ST_JTAG_ACC: begin
        o_ram_addr = w_jtag_addr;
        o_ram_be   = '1;
        o_ram_we   = w_jtag_wr;
        if (w_jtag_wr) begin
          o_ram_wdata = w_jtag_wdata;
        end
        w_next = ST_JTAG_DONE;
      end
      ST_JTAG_DONE: begin
        o_jtag_done = 1'b1;
        w_next      = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // RAM data is valid in the DONE cycle; it is forwarded then and held after
  assign w_cpu_rd_done  = (r_state == ST_CPU_DONE) & i_cpu_read & ~i_cpu_write;
  assign w_jtag_rd_done = (r_state == ST_JTAG_DONE) & ~w_jtag_wr;

  // Read-data holding registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cpu_rdata  <= '0;
      r_jtag_rdata <= '0;
    end else begin
      if (w_cpu_rd_done) begin
        r_cpu_rdata <= i_ram_rdata;
      end
      if (w_jtag_rd_done) begin
        r_jtag_rdata <= i_ram_rdata;
      end
    end
  end

  assign o_cpu_readdata    = w_cpu_rd_done  ? i_ram_rdata : r_cpu_rdata;
  assign o_jtag_rdata      = w_jtag_rd_done ? i_ram_rdata : r_jtag_rdata;
  assign o_cpu_waitrequest = reset | (w_cpu_req & (r_state != ST_CPU_DONE));

endmodule
`default_nettype wire

// File: tb/tb_ocimem_access_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tb_ocimem_access_arbiter                                   |
// | Purpose  : Self-checking bench for ocimem_access_arbiter (default     |
// |            build, fixed JTAG priority) with a RAM model, a            |
// |            transaction-level reference model and directed vectors.    |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
module tb_ocimem_access_arbiter;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        jld = 1'b0, jacc = 1'b0, jwr = 1'b0;
  logic [7:0]  jaddr = '0;
  logic [31:0] jwdata = '0;
  logic        cpu_rd = 1'b0, cpu_wr = 1'b0;
  logic [7:0]  caddr = '0;
  logic [31:0] cwdata = '0;
  logic [3:0]  cbe = '0;
  logic [31:0] ram_rdata;

  logic        jdone, jovr, cwait, rwe;
  logic [31:0] jrdata, crdata, rwdata;
  logic [7:0]  raddr;
  logic [3:0]  rbe;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ocimem_access_arbiter dut (
    .clk               (clk),
    .reset             (reset),
    .i_jtag_addr_ld    (jld),
    .i_jtag_addr_in    (jaddr),
    .i_jtag_acc        (jacc),
    .i_jtag_wr         (jwr),
    .i_jtag_wdata      (jwdata),
    .o_jtag_done       (jdone),
    .o_jtag_rdata      (jrdata),
    .o_jtag_overrun    (jovr),
    .i_cpu_address     (caddr),
    .i_cpu_read        (cpu_rd),
    .i_cpu_write       (cpu_wr),
    .i_cpu_writedata   (cwdata),
    .i_cpu_byteenable  (cbe),
    .o_cpu_waitrequest (cwait),
    .o_cpu_readdata    (crdata),
    .o_ram_addr        (raddr),
    .o_ram_we          (rwe),
    .o_ram_be          (rbe),
    .o_ram_wdata       (rwdata),
    .i_ram_rdata       (ram_rdata)
  );

  // ---------------- RAM model (256x32, 1-cycle read latency) ----------------
  logic [31:0] mem [256];

  function automatic logic [31:0] init_val(input int i);
    case (i)
      'h11:    return 32'h12345678;
      'hFF:    return 32'hCAFEF00D;
      'h00:    return 32'h0BADF00D;
      default: return 32'hA5000000 | 32'(i);
    endcase
  endfunction

  // Synchronous RAM with byte-lane writes; reloaded while reset is high
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      ram_rdata <= '0;
    end else begin
      if (rwe) begin
        for (int b = 0; b < 4; b++)
          if (rbe[b]) mem[raddr][8*b +: 8] <= rwdata[8*b +: 8];
      end
      ram_rdata <= mem[raddr];
    end
  end

  // ---------------- Reference model ----------------
  // Owner of the RAM slot: 0 none, 1 cpu, 2 jtag; phase: 0 free, 1 access, 2 done
  int          m_owner, m_phase;
  logic [7:0]  m_ptr, m_paddr;
  logic        m_pend, m_pwr, m_ovr;
  logic [31:0] m_pwdata, m_jrd, m_crd;

  // Transaction-level progress of requests
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_owner <= 0; m_phase <= 0; m_ptr <= '0; m_paddr <= '0;
      m_pend <= 1'b0; m_pwr <= 1'b0; m_ovr <= 1'b0;
      m_pwdata <= '0; m_jrd <= '0; m_crd <= '0;
    end else begin
      if (m_phase == 0) begin
        if (m_pend) begin
          m_owner <= 2; m_phase <= 1;
        end else if (cpu_rd || cpu_wr) begin
          m_owner <= 1; m_phase <= 1;
        end
      end else if (m_phase == 1) begin
        m_phase <= 2;
      end else begin
        m_phase <= 0; m_owner <= 0;
        if (m_owner == 2) begin
          m_pend <= 1'b0;
          if (!m_pwr) m_jrd <= mem[m_paddr];
        end
        if (m_owner == 1 && cpu_rd && !cpu_wr) m_crd <= mem[caddr];
      end
      if (jacc && !m_pend) begin
        m_paddr  <= jld ? jaddr : m_ptr;
        m_ptr    <= (jld ? jaddr : m_ptr) + 8'd1;
        m_pwr    <= jwr;
        m_pwdata <= jwdata;
        m_pend   <= 1'b1;
      end else if (jld) begin
        m_ptr <= jaddr;
      end
      if (jacc && m_pend) m_ovr <= 1'b1;
      else if (jld)       m_ovr <= 1'b0;
    end
  end

  logic        e_wait, e_jdone, e_rwe;
  logic [31:0] e_jrd, e_crd, e_rwd;
  logic [7:0]  e_raddr;
  logic [3:0]  e_rbe;

  // Expected outputs for the current cycle
  always_comb begin
    e_wait  = reset | ((cpu_rd | cpu_wr) & ~(m_owner == 1 && m_phase == 2));
    e_jdone = (m_owner == 2 && m_phase == 2);
    e_jrd   = (e_jdone && !m_pwr) ? mem[m_paddr] : m_jrd;
    e_crd   = (m_owner == 1 && m_phase == 2 && cpu_rd && !cpu_wr) ? mem[caddr] : m_crd;
    e_raddr = '0; e_rwe = 1'b0; e_rbe = '0; e_rwd = '0;
    if (m_phase == 1 && m_owner == 1) begin
      e_raddr = caddr; e_rbe = cbe; e_rwe = cpu_wr; e_rwd = cpu_wr ? cwdata : '0;
    end else if (m_phase == 1 && m_owner == 2) begin
      e_raddr = m_paddr; e_rbe = 4'hF; e_rwe = m_pwr; e_rwd = m_pwr ? m_pwdata : '0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("waitrequest", 32'(cwait), 32'(e_wait));
    chk("jtag_done", 32'(jdone), 32'(e_jdone));
    chk("jtag_rdata", jrdata, e_jrd);
    chk("jtag_overrun", 32'(jovr), 32'(m_ovr));
    chk("cpu_readdata", crdata, e_crd);
    chk("ram_addr", 32'(raddr), 32'(e_raddr));
    chk("ram_we", 32'(rwe), 32'(e_rwe));
    chk("ram_be", 32'(rbe), 32'(e_rbe));
    chk("ram_wdata", rwdata, e_rwd);
  end

  // ---------------- Stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One JTAG access; returns address/we/wdata seen in the access cycle
  task automatic jtag_op(input logic ld, input logic [7:0] a, input logic wr,
                         input logic [31:0] d, output logic [7:0] acc_addr,
                         output logic acc_we, output logic [31:0] acc_wd,
                         output logic [31:0] rd, output int lat);
    jld = ld; jaddr = a; jacc = 1'b1; jwr = wr; jwdata = d;
    tick();
    jld = 1'b0; jacc = 1'b0;
    lat = 1; acc_addr = '0; acc_we = 1'b0; acc_wd = '0; rd = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (jdone) begin
        rd = jrdata;
        break;
      end
      acc_addr = raddr; acc_we = rwe; acc_wd = rwdata;
      lat++;
    end
    tick();
  endtask

  // One Avalon transfer; nwait counts cycles with waitrequest high
  task automatic cpu_op(input logic rd, input logic wr, input logic [7:0] a,
                        input logic [31:0] d, input logic [3:0] be,
                        output logic [31:0] q, output int nwait);
    cpu_rd = rd; cpu_wr = wr; caddr = a; cwdata = d; cbe = be;
    nwait = 0; q = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!cwait) begin
        q = crdata;
        break;
      end
      nwait++;
    end
    tick();
    cpu_rd = 1'b0; cpu_wr = 1'b0;
  endtask

  // ---------------- Directed sequence ----------------
  initial begin
    logic [7:0]  a;
    logic        we;
    logic [31:0] wd, q;
    int          lat, nw, ndone, jd_at, wl_at;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wait", 32'(cwait), 32'd1);
    chk("rst_ram_we", 32'(rwe), 32'd0);
    chk("rst_jdone", 32'(jdone), 32'd0);
    chk("rst_crdata", crdata, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    tick();

    // Load 0x10, JTAG write
    jtag_op(1'b1, 8'h10, 1'b1, 32'hDEADBEEF, a, we, wd, q, lat);
    chk("t1_addr", 32'(a), 32'h10);
    chk("t1_we", 32'(we), 32'd1);
    chk("t1_wdata", wd, 32'hDEADBEEF);
    chk("t1_latency", lat, 3);
    chk("t1_mem", mem[8'h10], 32'hDEADBEEF);

    // Pointer must now be 0x11
    jtag_op(1'b0, 8'h00, 1'b0, 32'h0, a, we, wd, q, lat);
    chk("t1_ptr_addr", 32'(a), 32'h11);
    chk("t1_rd_we", 32'(we), 32'd0);
    chk("t1_rdata", q, 32'h12345678);

    // CPU read at 0x11
    cpu_op(1'b1, 1'b0, 8'h11, 32'h0, 4'hF, q, nw);
    chk("t2_nwait", nw, 2);
    chk("t2_rdata", q, 32'h12345678);

    // Pointer wrap
    jtag_op(1'b1, 8'hFF, 1'b0, 32'h0, a, we, wd, q, lat);
    chk("t3_addr_ff", 32'(a), 32'hFF);
    chk("t3_rdata_ff", q, 32'hCAFEF00D);
    jtag_op(1'b0, 8'h00, 1'b0, 32'h0, a, we, wd, q, lat);
    chk("t3_addr_00", 32'(a), 32'h00);
    chk("t3_rdata_00", q, 32'h0BADF00D);
    jtag_op(1'b0, 8'h00, 1'b0, 32'h0, a, we, wd, q, lat);
    chk("t3_addr_01", 32'(a), 32'h01);
    chk("t3_rdata_01", q, 32'hA5000001);

    // Overrun: second access dropped; coincident load keeps overrun set
    jacc = 1'b1; jwr = 1'b0; jld = 1'b0;
    tick();
    jacc = 1'b1; jld = 1'b1; jaddr = 8'h40;
    tick();
    jacc = 1'b0; jld = 1'b0;
    chk("t4_ovr_set", 32'(jovr), 32'd1);
    ndone = 0; a = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (jdone) ndone++;
      if (rbe == 4'hF) a = raddr;
    end
    chk("t4_one_access", ndone, 1);
    chk("t4_access_addr", 32'(a), 32'h02);
    tick();
    jtag_op(1'b0, 8'h00, 1'b0, 32'h0, a, we, wd, q, lat);
    chk("t4_ptr_reloaded", 32'(a), 32'h40);
    chk("t4_ovr_sticky", 32'(jovr), 32'd1);
    jld = 1'b1; jaddr = 8'h50;
    tick();
    jld = 1'b0;
    chk("t4_ovr_clear", 32'(jovr), 32'd0);

    // CPU read+write together acts as a byte-lane write
    cpu_op(1'b1, 1'b1, 8'h20, 32'h11223344, 4'b0101, q, nw);
    chk("t5_nwait", nw, 2);
    chk("t5_rdata_hold", q, 32'h12345678);
    chk("t5_mem", mem[8'h20], 32'hA5220044);

    // Contention: JTAG pending when CPU arrives; JTAG first
    jld = 1'b1; jaddr = 8'h30; jacc = 1'b1; jwr = 1'b0;
    tick();
    jld = 1'b0; jacc = 1'b0;
    cpu_rd = 1'b1; caddr = 8'h20; cbe = 4'hF;
    jd_at = -1; wl_at = -1; q = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (jdone && jd_at < 0) jd_at = k;
      if (!cwait) begin
        wl_at = k; q = crdata;
        break;
      end
    end
    tick();
    cpu_rd = 1'b0;
    chk("t6_jtag_done_at", jd_at, 2);
    chk("t6_cpu_done_at", wl_at, 5);
    chk("t6_cpu_rdata", q, 32'hA5220044);
    chk("t6_jtag_rdata", jrdata, 32'hA5000030);

    // Reset while the CPU access is in its RAM cycle
    cpu_rd = 1'b1; caddr = 8'h11; cbe = 4'hF;
    tick();
    chk("t7_in_access", 32'(rbe), 32'hF);
    reset = 1'b1;
    #1;
    chk("t7_wait", 32'(cwait), 32'd1);
    chk("t7_ram_we", 32'(rwe), 32'd0);
    chk("t7_ram_addr", 32'(raddr), 32'd0);
    chk("t7_ram_be", 32'(rbe), 32'd0);
    chk("t7_jdone", 32'(jdone), 32'd0);
    chk("t7_jrdata", jrdata, 32'd0);
    chk("t7_crdata", crdata, 32'd0);
    cpu_rd = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    jtag_op(1'b0, 8'h00, 1'b0, 32'h0, a, we, wd, q, lat);
    chk("t7_ptr_reset", 32'(a), 32'h00);
    chk("t7_post_rdata", q, 32'h0BADF00D);
    cpu_op(1'b1, 1'b0, 8'hFF, 32'h0, 4'hF, q, nw);
    chk("t7_cpu_nwait", nw, 2);
    chk("t7_cpu_rdata", q, 32'hCAFEF00D);

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Safety net against a hung run
  initial begin
    #200000;
    n_fail++;
    $display("FAIL global_timeout: got running expected finished");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
